// File: rtl/gb_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gb_mem_pkg
//  Brief    : Shared types and constants for the GameBoy memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package gb_mem_pkg;

   // Bus widths of the GameBoy CPU and video buses.
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   // Encoding of mem_src: which requester owns the current transaction.
   localparam logic SRC_CPU = 1'b0;
   localparam logic SRC_VID = 1'b1;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_ACK = 2'd2
   } arb_state_t;

endpackage : gb_mem_pkg
`default_nettype wire

// File: rtl/gb_mem_port.sv
`default_nettype none
// ============================================================================
//  Module   : gb_mem_port
//  Brief    : Per-requester front end. Decodes the active-low strobes, tracks
//             whether the current access has already been served, holds the
//             read-data register and drives the active-low wait line.
//  Revision : 1.0 - initial release
// ============================================================================
module gb_mem_port
   import gb_mem_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] A,
   input  logic              rd_n,
   input  logic              wr_n,
   input  logic              cs_n,
   input  logic              grant,     // this port wins arbitration this cycle
   input  logic              complete,  // this port's transaction ends (ack or timeout)
   input  logic              capture,   // read data for this port is on rdata
   input  logic [DATA_W-1:0] rdata,
   output logic              pending,
   output logic              is_write,
   output logic [DATA_W-1:0] Di,
   output logic              wait_n
);

   logic              active;
   logic              served;
   logic              served_q;
   logic [ADDR_W-1:0] last_addr;

   // Strobe decode and served/pending qualification. A stored served flag only
   // counts while the access is still active on the address it was granted for,
   // so a dropped strobe or a new address is a new request in the same cycle.
   always_comb begin
      active   = !cs_n && (!rd_n || !wr_n);
      is_write = !wr_n;
      served   = served_q && active && (A == last_addr);
      pending  = active && !served;
      wait_n   = !pending;
   end

   // Served tracking: remember the granted address, mark served on completion
   // only if the requester is still presenting that same access.
   always_ff @(posedge clock) begin
      if (reset) begin
         served_q  <= 1'b0;
         last_addr <= '0;
      end else begin
         if (grant) begin
            last_addr <= A;
         end
         if (complete) begin
            served_q <= active && (A == last_addr);
         end else begin
            served_q <= served;
         end
      end
   end

   // Read-data register: updated only by read completions, holds otherwise.
   always_ff @(posedge clock) begin
      if (reset) begin
         Di <= '0;
      end else if (capture) begin
         Di <= rdata;
      end
   end

endmodule : gb_mem_port
`default_nettype wire

// File: rtl/gb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gb_mem_arbiter
//  Brief    : Shares one single-port memory between the GameBoy CPU bus and
//             video bus. Video normally wins; a pending CPU access is forced
//             through after VID_STREAK_MAX consecutive video grants. One
//             transaction at a time, with an optional ack timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module gb_mem_arbiter
   import gb_mem_pkg::*;
#(
   parameter int VID_STREAK_MAX = 4,
   parameter int ACK_TIMEOUT    = 255
)(
   input  logic              clock,
   input  logic              reset,
   // CPU bus
   input  logic [ADDR_W-1:0] cpu_A,
   input  logic [DATA_W-1:0] cpu_Do,
   output logic [DATA_W-1:0] cpu_Di,
   input  logic              cpu_rd_n,
   input  logic              cpu_wr_n,
   input  logic              cpu_cs_n,
   output logic              cpu_wait_n,
   // Video bus
   input  logic [ADDR_W-1:0] vid_A,
   input  logic [DATA_W-1:0] vid_Do,
   output logic [DATA_W-1:0] vid_Di,
   input  logic              vid_rd_n,
   input  logic              vid_wr_n,
   input  logic              vid_cs_n,
   output logic              vid_wait_n,
   // Memory controller side
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_src,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              timeout_err
);

   // The streak counter saturates at VID_STREAK_MAX; the timeout counter runs
   // 0 .. ACK_TIMEOUT-1 while waiting for an ack.
   localparam int STREAK_W = $clog2(VID_STREAK_MAX + 1);
   localparam int TMO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(VID_STREAK_MAX);
   localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);

   arb_state_t          state;
   arb_state_t          state_nxt;
   logic [STREAK_W-1:0] streak;
   logic [TMO_W-1:0]    tmo_cnt;

   logic cpu_pending;
   logic cpu_is_write;
   logic vid_pending;
   logic vid_is_write;

   logic grant_any;
   logic grant_vid;
   logic ack_done;
   logic tmo_done;
   logic complete;

   logic cpu_grant;
   logic cpu_complete;
   logic cpu_capture;
   logic vid_grant;
   logic vid_complete;
   logic vid_capture;

   // ------------------------------------------------------------------------
   // Requester front ends
   // ------------------------------------------------------------------------
   gb_mem_port u_cpu_port (
      .clock    (clock),
      .reset    (reset),
      .A        (cpu_A),
      .rd_n     (cpu_rd_n),
      .wr_n     (cpu_wr_n),
      .cs_n     (cpu_cs_n),
      .grant    (cpu_grant),
      .complete (cpu_complete),
      .capture  (cpu_capture),
      .rdata    (mem_rdata),
      .pending  (cpu_pending),
      .is_write (cpu_is_write),
      .Di       (cpu_Di),
      .wait_n   (cpu_wait_n)
   );

   gb_mem_port u_vid_port (
      .clock    (clock),
      .reset    (reset),
      .A        (vid_A),
      .rd_n     (vid_rd_n),
      .wr_n     (vid_wr_n),
      .cs_n     (vid_cs_n),
      .grant    (vid_grant),
      .complete (vid_complete),
      .capture  (vid_capture),
      .rdata    (mem_rdata),
      .pending  (vid_pending),
      .is_write (vid_is_write),
      .Di       (vid_Di),
      .wait_n   (vid_wait_n)
   );

   // Arbitration and completion decode. Acks outside WAIT_ACK are ignored.
   always_comb begin
      grant_vid = vid_pending && !(cpu_pending && (streak == STREAK_SAT));
      grant_any = (state == IDLE) && (cpu_pending || vid_pending);
      ack_done  = (state == WAIT_ACK) && mem_ack;
      tmo_done  = (state == WAIT_ACK) && !mem_ack && (ACK_TIMEOUT != 0) &&
                  (tmo_cnt == TMO_LAST);
      complete  = ack_done || tmo_done;
   end

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: one transaction at a time, straight back to IDLE on
   // completion so a second pending requester is granted the very next cycle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (grant_any) state_nxt = ISSUE;
         ISSUE:    state_nxt = WAIT_ACK;
         WAIT_ACK: if (complete)  state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Output decode: route grant and completion strobes to the owning port.
   always_comb begin
      cpu_grant    = grant_any && !grant_vid;
      vid_grant    = grant_any &&  grant_vid;
      cpu_complete = complete && (mem_src == SRC_CPU);
      vid_complete = complete && (mem_src == SRC_VID);
      cpu_capture  = ack_done && !mem_we && (mem_src == SRC_CPU);
      vid_capture  = ack_done && !mem_we && (mem_src == SRC_VID);
   end

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------

   // Memory request registers: latched at grant, held stable until completion.
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_src   <= SRC_CPU;
         mem_wdata <= '0;
      end else if (grant_any) begin
         mem_req   <= 1'b1;
         mem_src   <= grant_vid ? SRC_VID      : SRC_CPU;
         mem_addr  <= grant_vid ? vid_A        : cpu_A;
         mem_wdata <= grant_vid ? vid_Do       : cpu_Do;
         mem_we    <= grant_vid ? vid_is_write : cpu_is_write;
      end else if (complete) begin
         mem_req   <= 1'b0;
      end
   end

   // Video streak: counts video wins over a waiting CPU, cleared whenever the
   // CPU wins or stops waiting.
   always_ff @(posedge clock) begin
      if (reset) begin
         streak <= '0;
      end else if (!cpu_pending || cpu_grant) begin
         streak <= '0;
      end else if (vid_grant && (streak != STREAK_SAT)) begin
         streak <= streak + 1'b1;
      end
   end

   // Ack timeout: counts WAIT_ACK cycles, restarts on every other state.
   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (state != WAIT_ACK) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   // Sticky timeout flag, only cleared by reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         timeout_err <= 1'b0;
      end else if (tmo_done) begin
         timeout_err <= 1'b1;
      end
   end

endmodule : gb_mem_arbiter
`default_nettype wire

// File: tb/tb_gb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gb_mem_arbiter
//  Brief    : Self-checking bench for gb_mem_arbiter: directed corner cases
//             plus randomized traffic against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gb_mem_arbiter;

   localparam int VSM = 4;
   localparam int TMO = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] cpu_A, vid_A, mem_addr;
   logic [7:0]  cpu_Do, cpu_Di, vid_Do, vid_Di, mem_wdata, mem_rdata;
   logic        cpu_rd_n, cpu_wr_n, cpu_cs_n, cpu_wait_n;
   logic        vid_rd_n, vid_wr_n, vid_cs_n, vid_wait_n;
   logic        mem_req, mem_we, mem_src, mem_ack, timeout_err;

   int n_assert = 0;
   int n_fail   = 0;

   // Transaction-level model: per port (0 = CPU, 1 = video) outstanding flag,
   // the access it presents, and the expected Di.
   bit          out_m[2];
   logic [15:0] addr_m[2];
   bit          we_m[2];
   logic [7:0]  wd_m[2];
   logic [7:0]  di_m[2];
   int          streak_m;
   bit          txn_m;
   int          src_m;
   bit          prev_req;
   int          ack_cnt;
   bit          issue_en;
   bit          vid_always;
   int          rate;
   int          cnt;

   always #5 clock = ~clock;

   gb_mem_arbiter #(.VID_STREAK_MAX(VSM), .ACK_TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset),
      .cpu_A(cpu_A), .cpu_Do(cpu_Do), .cpu_Di(cpu_Di),
      .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_cs_n(cpu_cs_n),
      .cpu_wait_n(cpu_wait_n),
      .vid_A(vid_A), .vid_Do(vid_Do), .vid_Di(vid_Di),
      .vid_rd_n(vid_rd_n), .vid_wr_n(vid_wr_n), .vid_cs_n(vid_cs_n),
      .vid_wait_n(vid_wait_n),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_src(mem_src), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .timeout_err(timeout_err)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // kind: 0 = read, 1 = write, 2 = both strobes low (write)
   task automatic drive(input int p, input bit act, input logic [15:0] a,
                        input int kind, input logic [7:0] d);
      logic rd;
      logic wr;
      rd = !(act && kind != 1);
      wr = !(act && kind != 0);
      if (p == 0) begin
         cpu_cs_n = !act; cpu_A = a; cpu_Do = d; cpu_rd_n = rd; cpu_wr_n = wr;
      end else begin
         vid_cs_n = !act; vid_A = a; vid_Do = d; vid_rd_n = rd; vid_wr_n = wr;
      end
   endtask

   task automatic issue(input int p, input logic [15:0] a);
      int         kind;
      logic [7:0] d;
      kind = int'($urandom_range(0, 2));
      d    = 8'($urandom);
      drive(p, 1'b1, a, kind, d);
      out_m[p]  = 1'b1;
      addr_m[p] = a;
      we_m[p]   = (kind != 0);
      wd_m[p]   = d;
   endtask

   // One cycle of randomized traffic: check completions and grants against
   // the model, answer the memory request, then update requester stimulus.
   task automatic step();
      bit done_now[2];
      bit just_granted;
      int exp_src;
      done_now[0] = 1'b0;
      done_now[1] = 1'b0;
      just_granted = 1'b0;
      @(negedge clock);
      if (txn_m && mem_ack) begin
         if (!we_m[src_m]) di_m[src_m] = mem_rdata;
         out_m[src_m]    = 1'b0;
         done_now[src_m] = 1'b1;
         txn_m           = 1'b0;
         chk("done_req_low", 16'(mem_req), 16'd0);
      end
      if (mem_req && !prev_req) begin
         exp_src = (out_m[1] && !(out_m[0] && streak_m == VSM)) ? 1 : 0;
         chk("grant_has_pending", 16'(out_m[exp_src]), 16'd1);
         chk("grant_src", 16'(mem_src), 16'(exp_src));
         chk("grant_addr", mem_addr, addr_m[exp_src]);
         chk("grant_we", 16'(mem_we), 16'(we_m[exp_src]));
         chk("grant_wdata", 16'(mem_wdata), 16'(wd_m[exp_src]));
         if (!out_m[0] || exp_src == 0) streak_m = 0;
         else if (streak_m < VSM)       streak_m = streak_m + 1;
         src_m        = exp_src;
         txn_m        = 1'b1;
         ack_cnt      = int'($urandom_range(1, 3));
         just_granted = 1'b1;
      end
      chk("cpu_wait_n", 16'(cpu_wait_n), 16'(!out_m[0]));
      chk("vid_wait_n", 16'(vid_wait_n), 16'(!out_m[1]));
      chk("cpu_Di", 16'(cpu_Di), 16'(di_m[0]));
      chk("vid_Di", 16'(vid_Di), 16'(di_m[1]));
      chk("timeout_err_clear", 16'(timeout_err), 16'd0);
      prev_req = mem_req;
      mem_ack  = 1'b0;
      if (txn_m && !just_granted) begin
         ack_cnt--;
         if (ack_cnt == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'($urandom);
         end
      end
      for (int p = 0; p < 2; p++) begin
         if (done_now[p]) begin
            if (issue_en && ((p == 1 && vid_always) || $urandom_range(0, 1) == 1))
               issue(p, addr_m[p] ^ 16'(1 + $urandom_range(0, 254)));
            else
               drive(p, 1'b0, addr_m[p], 0, 8'h00);
         end else if (!out_m[p] && issue_en && int'($urandom_range(0, 99)) < rate) begin
            issue(p, 16'($urandom));
         end
      end
   endtask

   initial begin
      reset = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00;
      drive(0, 1'b0, 16'h0000, 0, 8'h00);
      drive(1, 1'b0, 16'h0000, 0, 8'h00);
      repeat (3) @(negedge clock);
      chk("rst_mem_req", 16'(mem_req), 16'd0);
      chk("rst_mem_we", 16'(mem_we), 16'd0);
      chk("rst_mem_addr", mem_addr, 16'h0000);
      chk("rst_mem_src", 16'(mem_src), 16'd0);
      chk("rst_mem_wdata", 16'(mem_wdata), 16'd0);
      chk("rst_timeout", 16'(timeout_err), 16'd0);
      chk("rst_cpu_Di", 16'(cpu_Di), 16'd0);
      chk("rst_vid_Di", 16'(vid_Di), 16'd0);
      reset = 1'b0;
      @(negedge clock);

      // CPU read 0xC000, ack on the first WAIT_ACK cycle.
      drive(0, 1'b1, 16'hC000, 0, 8'h00);
      @(negedge clock);
      chk("t1_req", 16'(mem_req), 16'd1);
      chk("t1_addr", mem_addr, 16'hC000);
      chk("t1_src", 16'(mem_src), 16'd0);
      chk("t1_wait_c1", 16'(cpu_wait_n), 16'd0);
      @(negedge clock);
      chk("t1_wait_c2", 16'(cpu_wait_n), 16'd0);
      mem_ack = 1'b1; mem_rdata = 8'h5A;
      @(negedge clock);
      mem_ack = 1'b0;
      chk("t1_Di", 16'(cpu_Di), 16'h005A);
      chk("t1_wait_c3", 16'(cpu_wait_n), 16'd1);
      chk("t1_req_done", 16'(mem_req), 16'd0);
      drive(0, 1'b0, 16'hC000, 0, 8'h00);
      @(negedge clock);

      // CPU write 0xFF40 <- 0x91 with both strobes low.
      drive(0, 1'b1, 16'hFF40, 2, 8'h91);
      @(negedge clock);
      chk("t4_we", 16'(mem_we), 16'd1);
      chk("t4_wdata", 16'(mem_wdata), 16'h0091);
      chk("t4_addr", mem_addr, 16'hFF40);
      @(negedge clock);
      mem_ack = 1'b1; mem_rdata = 8'hEE;
      @(negedge clock);
      mem_ack = 1'b0;
      chk("t4_Di_kept", 16'(cpu_Di), 16'h005A);
      chk("t4_wait", 16'(cpu_wait_n), 16'd1);
      drive(0, 1'b0, 16'hFF40, 0, 8'h00);
      @(negedge clock);

      // Randomized traffic: first with video re-requesting continuously to
      // exercise the streak limit, then mixed traffic.
      out_m[0] = 1'b0; out_m[1] = 1'b0;
      di_m[0] = 8'h5A; di_m[1] = 8'h00;
      streak_m = 0; txn_m = 1'b0; prev_req = 1'b0; ack_cnt = 0;
      issue_en = 1'b1; vid_always = 1'b1; rate = 60;
      repeat (200) step();
      vid_always = 1'b0; rate = 30;
      repeat (500) step();
      issue_en = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (!out_m[0] && !out_m[1] && !txn_m) break;
         step();
      end
      chk("drain", 16'({out_m[0], out_m[1], txn_m}), 16'd0);
      @(negedge clock);
      mem_ack = 1'b0;

      // Ack timeout, then a stray ack.
      drive(0, 1'b1, 16'h1234, 0, 8'h00);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (mem_req) cnt++;
         else if (cnt > 0) break;
      end
      chk("t5_req_cycles", 16'(cnt), 16'(1 + TMO));
      chk("t5_timeout_err", 16'(timeout_err), 16'd1);
      chk("t5_wait", 16'(cpu_wait_n), 16'd1);
      chk("t5_Di_kept", 16'(cpu_Di), 16'(di_m[0]));
      mem_ack = 1'b1; mem_rdata = 8'h77;
      @(negedge clock);
      mem_ack = 1'b0;
      chk("t5_stray_Di", 16'(cpu_Di), 16'(di_m[0]));
      chk("t5_stray_req", 16'(mem_req), 16'd0);
      chk("t5_sticky", 16'(timeout_err), 16'd1);
      drive(0, 1'b0, 16'h1234, 0, 8'h00);
      @(negedge clock);

      // Reset while waiting for the ack, ack arrives afterwards.
      drive(1, 1'b1, 16'h8000, 0, 8'h00);
      @(negedge clock);
      chk("t6_req_issue", 16'(mem_req), 16'd1);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("t6_req_rst", 16'(mem_req), 16'd0);
      chk("t6_vid_Di_rst", 16'(vid_Di), 16'd0);
      chk("t6_cpu_Di_rst", 16'(cpu_Di), 16'd0);
      chk("t6_timeout_rst", 16'(timeout_err), 16'd0);
      reset = 1'b0;
      mem_ack = 1'b1; mem_rdata = 8'hAB;
      drive(1, 1'b0, 16'h8000, 0, 8'h00);
      @(negedge clock);
      mem_ack = 1'b0;
      chk("t6_req_after", 16'(mem_req), 16'd0);
      chk("t6_vid_Di_after", 16'(vid_Di), 16'd0);
      @(negedge clock);
      chk("t6_idle", 16'(mem_req), 16'd0);
      chk("t6_vid_wait", 16'(vid_wait_n), 16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_gb_mem_arbiter
`default_nettype wire
